alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
//  Downstream retire stage of the 16-bit-operand / 32-bit-result combinational ALU.
//  - Same cycle: samples the ALU result together with the op and operands that produced it.
//  - Adds status flags to each result.
//  - Queues results in a small first-word-fall-through (FWFT) FIFO with valid/ready on both sides.
//  - Back-pressures the operand source feeding the ALU and counts stall cycles.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  RES_W   32  ALU result width
//  OPD_W   16  ALU operand width
//  OP_W    3   ALU opcode width
//  CNT_W   16  stall counter width
// PORTS
//  clk         in   1                 single clock, rising edge
//  rst_n       in   1                 synchronous, active-low reset
//  in_valid    in   1                 in_op/in_a/in_b/in_result are valid this cycle
//  in_ready    out  1                 buffer accepts this cycle
//  in_op       in   OP_W              opcode applied to the ALU
//  in_a        in   OPD_W             operand A applied to the ALU
//  in_b        in   OPD_W             operand B applied to the ALU
//  in_result   in   RES_W             ALU result for in_op/in_a/in_b
//  out_valid   out  1                 head entry valid
//  out_ready   in   1                 consumer takes head entry
//  out_result  out  RES_W             head result
//  out_op      out  OP_W              head opcode
//  out_flags   out  4                 {div0, borrow, carry, zero}
//  level       out  $clog2(DEPTH+1)   current occupancy
//  stall_cnt   out  CNT_W             saturating count of in_valid && !in_ready cycles
// BEHAVIOUR
//  Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 OR, 101 AND, 110 NOTA, 111 NOTB.
//  Flags, computed combinationally from in_* at push:
//   zero   = (in_result == 0)
//   carry  = ADD && in_result[OPD_W]
//   borrow = SUB && (in_a < in_b)          (operands unsigned)
//   div0   = DIV && (in_b == 0)
//  - in_result is stored unmodified, including when div0 is set.
//  - in_result is not checked against in_op.
//  Handshake: push = in_valid && in_ready; pop = out_valid && out_ready.
//  - in_ready = (level < DEPTH); it does not depend on out_ready in the same cycle.
//  - out_valid = (level != 0).
//  - out_* show the head entry (FWFT). They are forced to 0 while out_valid = 0.
//  Latency: an entry pushed at edge N has out_valid = 1 in the cycle after edge N.
//  - No same-cycle bypass when empty.
//  Occupancy states (derived from level, no separate FSM register):
//   EMPTY   level == 0: push -> PARTIAL
//   PARTIAL 0 < level < DEPTH:
//     push only -> level+1; reaching DEPTH -> FULL
//     pop only  -> level-1; reaching 0 -> EMPTY
//     push && pop -> level unchanged
//   FULL    level == DEPTH: in_ready = 0; pop -> PARTIAL
//  Boundary rules:
//   - In FULL with pop, there is no push that cycle, even if in_valid is high.
//   - Pointers wrap modulo DEPTH.
//   - stall_cnt increments on every in_valid && !in_ready cycle and saturates at all-ones.
//   - Source obligation: a stalled source holds in_op/in_a/in_b stable until accepted.
//  Reset (rst_n = 0 at an edge, including mid-stream):
//   - level, pointers and stall_cnt go to 0.
//   - Queued entries are discarded.
//   - Storage array contents are not reset.
//   - Outputs the cycle after reset: out_valid = 0, out_result/out_op/out_flags = 0, in_ready = 1.
// STRUCTURE
//  Package alu_pkg holds:
//   - ALU opcode localparams (OP_ADD .. OP_NOTB).
//   - Flag bit indices (FLG_ZERO = 0, FLG_CARRY = 1, FLG_BORROW = 2, FLG_DIV0 = 3).
//   - The entry field widths.
//  Sub-module alu_flag_gen: combinational (in_op, in_a, in_b, in_result) -> flags[3:0].
//  Top module: FIFO storage, pointers, level and stall counter.
// TESTING
//  1) ADD a=16'hFFFF b=1, result=32'h0001_0000 -> next cycle out_valid=1, out_flags=4'b0010.
//  2) DIV a=7 b=0, result=0 -> out_flags=4'b1001, out_result=0.
//     SUB a=3 b=5, result=32'hFFFF_FFFE -> out_flags=4'b0100.
//  3) out_ready=0, push 5 entries back-to-back -> level=4 after 4 pushes, in_ready=0;
//     5th entry held, stall_cnt increments each held cycle;
//     then out_ready=1 -> entries pop in FIFO order.
//  4) level=2, push and pop in the same cycle for 10 cycles -> level stays 2;
//     results emerge in order across pointer wrap.
//  5) level=3, assert rst_n=0 for 1 cycle -> out_valid=0, level=0, stall_cnt=0, in_ready=1;
//     next push appears alone at the head.
//  6) Hold in_valid=1 with out_ready=0 while FULL for 2^CNT_W+5 cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU retire stage: opcodes, flag bit positions
// and the default widths of a buffered result entry.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  localparam int FLG_ZERO   = 0;
  localparam int FLG_CARRY  = 1;
  localparam int FLG_BORROW = 2;
  localparam int FLG_DIV0   = 3;
  localparam int FLG_W      = 4;

  localparam int DEF_RES_W = 32;
  localparam int DEF_OPD_W = 16;
  localparam int DEF_OP_W  = 3;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags for one ALU result, derived from the opcode,
// the operands and the result exactly as they were presented to the buffer.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int RES_W = DEF_RES_W,
  parameter int OPD_W = DEF_OPD_W,
  parameter int OP_W  = DEF_OP_W
) (
  input  logic [OP_W-1:0]  in_op,
  input  logic [OPD_W-1:0] in_a,
  input  logic [OPD_W-1:0] in_b,
  input  logic [RES_W-1:0] in_result,
  output logic [FLG_W-1:0] flags
);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    flags             = '0;
    flags[FLG_ZERO]   = (in_result == '0);
    // Carry is the bit just above the operand width of an ADD result.
    flags[FLG_CARRY]  = (in_op == OP_W'(OP_ADD)) && in_result[OPD_W];
    flags[FLG_BORROW] = (in_op == OP_W'(OP_SUB)) && (in_a < in_b);
    flags[FLG_DIV0]   = (in_op == OP_W'(OP_DIV)) && (in_b == '0);
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Retire stage behind the ALU: tags each result with flags, queues it in a
// first-word-fall-through FIFO and counts cycles the operand source is stalled.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RES_W = DEF_RES_W,
  parameter int OPD_W = DEF_OPD_W,
  parameter int OP_W  = DEF_OP_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [OPD_W-1:0]           in_a,
  input  logic [OPD_W-1:0]           in_b,
  input  logic [RES_W-1:0]           in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_result,
  output logic [OP_W-1:0]            out_op,
  output logic [FLG_W-1:0]           out_flags,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [OP_W-1:0]  op;
    logic [FLG_W-1:0] flags;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FLG_W-1:0] flags;
  logic             push;
  logic             pop;

  alu_flag_gen #(
    .RES_W (RES_W),
    .OPD_W (OPD_W),
    .OP_W  (OP_W)
  ) u_flag_gen (
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_result (in_result),
    .flags     (flags)
  );

  // Readiness depends only on occupancy, so a full buffer never accepts,
  // even in a cycle where the head is being popped.
  assign in_ready  = (level < LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: storage has no reset; entries are only observable once level covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{result: in_result, op: in_op, flags: flags};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      stall_cnt <= '0;
    end else begin
      // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (in_valid && !in_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_result = '0;
    out_op     = '0;
    out_flags  = '0;
    if (out_valid) begin
      out_result = mem[rd_ptr].result;
      out_op     = mem[rd_ptr].op;
      out_flags  = mem[rd_ptr].flags;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomised and directed bench for alu_result_buffer, checked every cycle
// against a queue-based model of the buffer.
module tb_alu_result_buffer;

  localparam int DEPTH   = 4;
  localparam int RES_W   = 32;
  localparam int OPD_W   = 16;
  localparam int OP_W    = 3;
  localparam int CNT_W   = 16;
  localparam int LVL_W   = $clog2(DEPTH+1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [OPD_W-1:0] in_a;
  logic [OPD_W-1:0] in_b;
  logic [RES_W-1:0] in_result;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic [OP_W-1:0]  out_op;
  logic [3:0]       out_flags;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  alu_result_buffer #(
    .DEPTH (DEPTH),
    .RES_W (RES_W),
    .OPD_W (OPD_W),
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_flags  (out_flags),
    .level      (level),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic [RES_W-1:0] res;
    logic [OP_W-1:0]  op;
    logic [3:0]       flags;
  } ent_t;

  ent_t q[$];
  int   stall_m;
  bit   last_push;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Flags written straight from the rule table: {div0, borrow, carry, zero}.
  function automatic logic [3:0] ref_flags(input logic [2:0] op, input int unsigned a,
                                           input int unsigned b, input logic [31:0] res);
    logic [3:0] f;
    f[0] = (res == 32'd0);
    f[1] = (op == 3'd0) && res[16];
    f[2] = (op == 3'd1) && (a < b);
    f[3] = (op == 3'd3) && (b == 0);
    return f;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    case (op)
      3'd0:    return {16'd0, a} + {16'd0, b};
      3'd1:    return {16'd0, a} - {16'd0, b};
      3'd2:    return {16'd0, a} * {16'd0, b};
      3'd3:    return (b == 0) ? 32'd0 : {16'd0, a / b};
      3'd4:    return {16'd0, a | b};
      3'd5:    return {16'd0, a & b};
      3'd6:    return {16'd0, ~a};
      default: return {16'd0, ~b};
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_result = alu(op, a, b);
  endtask

  task automatic compare();
    bit   has;
    ent_t h;
    has = (q.size() != 0);
    h   = has ? q[0] : '{res: '0, op: '0, flags: '0};
    check("out_valid", 64'(out_valid), 64'(has));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("level", 64'(level), 64'(q.size()));
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    check("out_result", 64'(out_result), 64'(h.res));
    check("out_op", 64'(out_op), 64'(h.op));
    check("out_flags", 64'(out_flags), 64'(h.flags));
  endtask

  // One clock: update the model with what the DUT sees at the edge, then compare.
  task automatic step();
    int   lvl;
    bit   push, pop;
    ent_t tmp;
    @(posedge clk);
    lvl       = q.size();
    push      = in_valid && (lvl < DEPTH);
    pop       = (lvl != 0) && out_ready;
    last_push = 1'b0;
    if (!rst_n) begin
      q.delete();
      stall_m = 0;
    end else begin
      if (in_valid && lvl >= DEPTH) stall_m = (stall_m >= CNT_MAX) ? CNT_MAX : stall_m + 1;
      if (pop) tmp = q.pop_front();
      if (push) begin
        q.push_back('{res: in_result, op: in_op,
                      flags: ref_flags(in_op, in_a, in_b, in_result)});
        last_push = 1'b1;
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic rand_entry();
    logic [2:0]  op;
    logic [15:0] a, b;
    op = 3'($urandom_range(0, 7));
    a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
    b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
    drive(op, a, b);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_result = '0;
    stall_m   = 0;
    last_push = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // ADD with carry out of the operand width.
    drive(3'd0, 16'hFFFF, 16'h0001);
    step();
    in_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_flags", 64'(out_flags), 64'b0010);
    check("add_result", 64'(out_result), 64'h0001_0000);
    out_ready = 1'b1;
    step();

    // DIV by zero, then SUB with borrow pushed while the DIV entry pops.
    out_ready = 1'b0;
    drive(3'd3, 16'd7, 16'd0);
    step();
    check("div0_flags", 64'(out_flags), 64'b1001);
    check("div0_result", 64'(out_result), 64'd0);
    out_ready = 1'b1;
    drive(3'd1, 16'd3, 16'd5);
    step();
    in_valid = 1'b0;
    check("sub_flags", 64'(out_flags), 64'b0100);
    check("sub_result", 64'(out_result), 64'hFFFF_FFFE);
    step();

    // Fill to FULL, stall a fifth entry, then drain in order.
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(3'd4, 16'(k + 16'h10), 16'h0100);
      step();
    end
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_ready", 64'(in_ready), 64'd0);
    drive(3'd5, 16'h0F0F, 16'h00FF);
    repeat (3) step();
    check("stall_3", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    step();
    check("full_pop_no_push", 64'(level), 64'(DEPTH - 1));
    check("head_after_pop", 64'(out_result), 64'h0000_0111);
    for (int i = 0; i < 2 * DEPTH && in_valid; i++) begin
      step();
      if (last_push) in_valid = 1'b0;
    end
    check("fifth_accepted", 64'(in_valid), 64'd0);
    repeat (DEPTH + 1) step();
    check("drained", 64'(out_valid), 64'd0);

    // Level 2, simultaneous push and pop across pointer wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(3'd2, 16'(k + 2), 16'd3);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(3'd0, 16'(k * 100), 16'd1);
      step();
    end
    in_valid = 1'b0;
    check("steady_level", 64'(level), 64'd2);
    check("steady_head", 64'(out_result), 64'd801);

    // Mid-stream reset at level 3.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(3'd6, 16'(k), 16'd0);
      step();
    end
    check("pre_reset_level", 64'(level), 64'd3);
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(out_result), 64'd0);
    drive(3'd7, 16'd0, 16'h1234);
    step();
    in_valid = 1'b0;
    check("post_rst_head", 64'(out_result), 64'h0000_EDCB);
    check("post_rst_level", 64'(level), 64'd1);

    // Randomised traffic with occasional resets; a stalled source holds its entry.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        if (!(in_valid && !last_push)) begin
          if ($urandom_range(0, 3) != 0) rand_entry();
          else in_valid = 1'b0;
        end
        out_ready = ($urandom_range(0, 2) != 0);
        step();
      end
    end

    // Saturation of the stall counter.
    do_reset();
    out_ready = 1'b0;
    drive(3'd0, 16'd1, 16'd1);
    repeat (DEPTH + CNT_MAX + 6) step();
    check("stall_saturated", 64'(stall_cnt), 64'hFFFF);
    check("sat_level", 64'(level), 64'(DEPTH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
